// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared types, constants and width helpers for the
//                set-associative L1 instruction cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    // Memory transfer type for a single 32-bit word access.
    localparam logic [2:0] CACHE_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Width of a way number; at least one bit even when direct mapped.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Number of tree-PLRU state bits per set; at least one bit so that
    // vectors stay legal in the direct-mapped case.
    function automatic int plru_w(input int ways);
        return (ways > 1) ? (ways - 1) : 1;
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - $clog2(sets) - $clog2(line_words) - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l1c_inst_sa_plru.sv
`default_nettype none
// ============================================================================
//  Module      : plru_tree
//  Description : Combinational tree pseudo-LRU for one set. Walks the tree
//                to produce the victim way and computes the updated state
//                bits after an access to a given way.
//  Revision    : 1.0 - initial release
// ============================================================================
module plru_tree
    import icache_pkg::*;
#(
    parameter int WAYS = 2
) (
    input  logic [plru_w(WAYS)-1:0] i_bits,
    input  logic [way_w(WAYS)-1:0]  i_acc_way,
    output logic [way_w(WAYS)-1:0]  o_victim,
    output logic [plru_w(WAYS)-1:0] o_next_bits
);

    localparam int LV = $clog2(WAYS);
    localparam int PB = plru_w(WAYS);
    localparam int NW = (PB > 1) ? $clog2(PB) : 1;
    localparam int WW = way_w(WAYS);

    logic [WW-1:0] w_vict;

    // Nodes are heap ordered: level l starts at node 2^l-1 and the node on the
    // path is selected by the way bits already decided above it. A bit of 1
    // means the victim lies in the upper half of that subtree.
    always_comb begin
        w_vict      = '0;
        o_next_bits = i_bits;
        for (int l = 0; l < LV; l++) begin
            w_vict[LV-1-l] = i_bits[NW'((1 << l) - 1 + int'(w_vict >> (LV - l)))];
            o_next_bits[NW'((1 << l) - 1 + int'(i_acc_way >> (LV - l)))] = ~i_acc_way[LV-1-l];
        end
    end

    assign o_victim = w_vict;

endmodule
`default_nettype wire

// File: rtl/l1c_inst_sa.sv
`default_nettype none
// ============================================================================
//  Module      : l1c_inst_sa
//  Description : N-way set-associative read-only L1 instruction cache with
//                tree PLRU replacement, whole-cache flush and saturating
//                hit/miss counters. All arrays live in flops so a hit
//                returns data in the request cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module l1c_inst_sa
    import icache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    output logic [31:0]       core_out,
    output logic              core_wait,
    input  logic              flush,
    output logic              I_req,
    output logic [ADDR_W-1:0] I_addr,
    output logic              I_write,
    output logic [2:0]        I_type,
    output logic [31:0]       I_in,
    input  logic [31:0]       I_out,
    input  logic              I_wait,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int WOFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam int WW     = way_w(WAYS);
    localparam logic [WOFF_W-1:0] c_last_beat = WOFF_W'(LINE_WORDS - 1);

    // Storage
    logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [31:0]       r_data  [WAYS][SETS][LINE_WORDS];
    logic [SETS-1:0]   r_valid [WAYS];

    // Control state
    state_t            r_state, w_next;
    logic              r_pend;
    logic [WW-1:0]     r_vway;
    logic [TAG_W-1:0]  r_tag_l;
    logic [IDX_W-1:0]  r_idx;
    logic [WOFF_W-1:0] r_woff;
    logic [WOFF_W-1:0] r_beat;
    logic [CNT_W-1:0]  r_hit_cnt, r_miss_cnt;

    // Address split and lookup
    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [WOFF_W-1:0] w_woff;
    logic              w_unused_lsb;
    logic [WAYS-1:0]   w_hit, w_set_valid;
    logic              w_any_hit;
    logic [WW-1:0]     w_hit_way, w_victim, w_plru_victim;
    logic              w_found_inv;

    // Control strobes
    logic              w_hit_inc, w_miss_inc, w_start, w_fill_wr, w_fill_last, w_clear;
    logic              w_plru_upd;
    logic [IDX_W-1:0]  w_plru_set;
    logic [WW-1:0]     w_plru_way;

    assign w_tag        = core_addr[ADDR_W-1 -: TAG_W];
    assign w_idx        = core_addr[WOFF_W+2 +: IDX_W];
    assign w_woff       = core_addr[2 +: WOFF_W];
    assign w_unused_lsb = ^core_addr[1:0];

    assign I_write  = 1'b0;
    assign I_type   = CACHE_WORD;
    assign I_in     = '0;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        assign w_set_valid[g] = r_valid[g][w_idx];
        assign w_hit[g]       = r_valid[g][w_idx] && (r_tag[g][w_idx] == w_tag);
    end

    assign w_any_hit = |w_hit;

    // Encode the (at most one) hitting way.
    always_comb begin
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_hit[w]) w_hit_way = WW'(w);
        end
    end

    // Prefer the lowest invalid way; fall back to the PLRU choice.
    always_comb begin
        w_victim    = w_plru_victim;
        w_found_inv = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found_inv && !w_set_valid[w]) begin
                w_victim    = WW'(w);
                w_found_inv = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next state, core/memory outputs and datapath strobes. Everything is
    // forced quiet while reset is asserted.
    always_comb begin
        w_next      = r_state;
        core_wait   = 1'b0;
        core_out    = '0;
        I_req       = 1'b0;
        I_addr      = '0;
        w_hit_inc   = 1'b0;
        w_miss_inc  = 1'b0;
        w_start     = 1'b0;
        w_fill_wr   = 1'b0;
        w_fill_last = 1'b0;
        w_clear     = 1'b0;
        w_plru_upd  = 1'b0;
        w_plru_set  = w_idx;
        w_plru_way  = w_hit_way;
        if (rst) begin
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        // Flush wins over a same-cycle lookup.
                        core_wait = core_req;
                        w_clear   = 1'b1;
                    end else if (core_req) begin
                        if (w_any_hit) begin
                            core_out   = r_data[w_hit_way][w_idx][w_woff];
                            w_hit_inc  = 1'b1;
                            w_plru_upd = 1'b1;
                        end else begin
                            core_wait  = 1'b1;
                            w_miss_inc = 1'b1;
                            w_start    = 1'b1;
                            w_next     = REFILL;
                        end
                    end
                end
                REFILL: begin
                    core_wait = 1'b1;
                    I_req     = 1'b1;
                    I_addr    = {r_tag_l, r_idx, r_beat, 2'b00};
                    if (!I_wait) begin
                        w_fill_wr = 1'b1;
                        if (r_beat == c_last_beat) begin
                            w_fill_last = 1'b1;
                            w_plru_upd  = 1'b1;
                            w_plru_set  = r_idx;
                            w_plru_way  = r_vway;
                            w_next      = DONE;
                        end
                    end
                end
                DONE: begin
                    core_out = r_data[r_vway][r_idx][r_woff];
                    w_clear  = r_pend || flush;
                    w_next   = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Miss bookkeeping, valid bits, pending flush and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend     <= 1'b0;
            r_vway     <= '0;
            r_tag_l    <= '0;
            r_idx      <= '0;
            r_woff     <= '0;
            r_beat     <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
        end else begin
            if (w_start) begin
                r_vway  <= w_victim;
                r_tag_l <= w_tag;
                r_idx   <= w_idx;
                r_woff  <= w_woff;
                r_beat  <= '0;
            end
            if (w_fill_wr) r_beat <= r_beat + 1'b1;
            // A flush seen during the refill must not leave the line valid.
            if (w_fill_last && !(r_pend || flush)) r_valid[r_vway][r_idx] <= 1'b1;
            if (w_clear) begin
                for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
            end
            if (w_clear)                         r_pend <= 1'b0;
            else if (flush && r_state != IDLE)   r_pend <= 1'b1;
            if (w_hit_inc && r_hit_cnt != '1)    r_hit_cnt  <= r_hit_cnt + 1'b1;
            if (w_miss_inc && r_miss_cnt != '1)  r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    // Tag and data arrays carry no reset.
    always_ff @(posedge clk) begin
        if (w_fill_wr)   r_data[r_vway][r_idx][r_beat] <= I_out;
        if (w_fill_last) r_tag[r_vway][r_idx]          <= r_tag_l;
    end

    if (WAYS > 1) begin : g_plru
        logic [plru_w(WAYS)-1:0] r_plru [SETS];
        logic [plru_w(WAYS)-1:0] w_next_bits;

        plru_tree #(.WAYS(WAYS)) u_plru (
            .i_bits      (r_plru[w_plru_set]),
            .i_acc_way   (w_plru_way),
            .o_victim    (w_plru_victim),
            .o_next_bits (w_next_bits)
        );

        // Per-set PLRU state; a flush clears every set.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
            end else if (w_clear) begin
                for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
            end else if (w_plru_upd) begin
                r_plru[w_plru_set] <= w_next_bits;
            end
        end
    end else begin : g_no_plru
        logic w_unused_plru;
        assign w_plru_victim = '0;
        assign w_unused_plru = ^{w_plru_upd, w_plru_set, w_plru_way};
    end

endmodule
`default_nettype wire

// File: doc/l1c_inst_sa.md
Name: l1c_inst_sa

Overview:
- Parametrised, N-way set-associative, read-only L1 instruction cache between the CPU core fetch port and the CPU wrapper's memory master port.
- Generalises the direct-mapped I-cache to the following:
  - configurable ways, sets and line length;
  - tree pseudo-LRU replacement;
  - single-cycle whole-cache flush for fence.i;
  - saturating hit/miss performance counters.
- Tag, valid, data and PLRU state are held in flops, so a lookup completes in the request cycle.

Parameters:
- WAYS, 2, associativity; power of two, 1..8.
- SETS, 64, sets per way; power of two, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, 2..16.
- ADDR_W, 32, address width.
- CNT_W, 32, width of each performance counter.
- Derived values:
  - WOFF_W = log2(LINE_WORDS)
  - IDX_W = log2(SETS)
  - TAG_W = ADDR_W - IDX_W - WOFF_W - 2

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: asynchronous, active-low.
- core_req, input, 1, fetch request.
- core_addr, input, ADDR_W, fetch byte address; word aligned, bits [1:0] ignored.
- core_out, output, 32, fetched instruction.
- core_wait, output, 1, stall the core; the fetch completes in the cycle where core_req=1 and core_wait=0.
- flush, input, 1, one-cycle pulse that invalidates the whole cache.
- I_req, output, 1, memory read request.
- I_addr, output, ADDR_W, memory word address.
- I_write, output, 1, tied to 0.
- I_type, output, 3, tied to CACHE_WORD.
- I_in, output, 32, tied to 0.
- I_out, input, 32, memory read data; valid in any cycle where I_req=1 and I_wait=0.
- I_wait, input, 1, memory stall.
- hit_cnt, output, CNT_W, number of hits.
- miss_cnt, output, CNT_W, number of misses.

Behaviour:
- Address split: core_addr[ADDR_W-1 -: TAG_W] is the tag, then the index (IDX_W bits), then the word offset (WOFF_W bits), then the byte bits [1:0].
- Reset (rst=0, asynchronous):
  - state goes to IDLE;
  - every valid bit, PLRU bit and counter is cleared;
  - the pending-flush flag is cleared;
  - outputs: core_wait=0, core_out=0, I_req=0, I_addr=0.
  - Data and tag arrays are not reset.
  - Reset asserted mid-refill abandons the burst immediately; I_req drops asynchronously.
- State IDLE:
  - Hit = valid & tag-equal in exactly one way of the indexed set.
  - core_req with a hit:
    - core_wait=0 and core_out = the hit word in the same cycle;
    - the set's PLRU is updated to point away from the hit way;
    - hit_cnt increments.
  - core_req with a miss:
    - core_wait=1 and miss_cnt increments;
    - the victim way and the line base address are latched;
    - beat counter = 0; go to REFILL.
  - Victim selection: the lowest-numbered invalid way; if all ways are valid, the PLRU way.
  - No request: core_wait=0, core_out=0.
- State REFILL:
  - I_req=1 and I_addr = line_base + 4*beat, in linear order starting at word 0.
  - On each cycle with I_wait=0, I_out is written to the victim way at word `beat` and beat increments.
  - On the beat LINE_WORDS-1 with I_wait=0:
    - the victim tag is written;
    - valid is set, unless a flush is pending;
    - the PLRU is updated toward the victim; go to DONE.
  - core_wait stays 1 throughout.
- State DONE:
  - core_out = the requested word from the filled line; core_wait=0 for one cycle.
  - If a flush is pending, apply it now (clear all valid and PLRU bits), then return to IDLE.
- Flush:
  - In IDLE: all valid and PLRU bits clear at the next edge.
  - If core_req is asserted in the same cycle, the flush has priority: core_wait=1, no lookup, no counter change. The lookup happens on the following cycle and misses.
  - During REFILL or DONE: the flush is latched as pending; the in-flight fetch still returns correct data.
- Counters: saturate at all ones and never wrap.
- Protocol rule: core_addr must stay stable while core_wait=1; no recovery is required if it changes.
- WAYS=1: degenerates to a direct-mapped cache; PLRU logic is absent.

Decomposition:
- Package icache_pkg holds:
  - the state enum (IDLE, REFILL, DONE);
  - the derived-width helper functions;
  - CACHE_WORD, re-exported from def.svh.
- One sub-module, plru_tree (parameter WAYS):
  - WAYS-1 state bits per set;
  - combinational victim output;
  - access-way update input.

Test Plan:
- Cold miss: WAYS=2, LINE_WORDS=4; fetch 0x0000_1008.
  - I_addr issues 0x1000, 0x1004, 0x1008, 0x100C; I_out = A0..A3.
  - With I_wait=1 for 2 cycles on beat 1, the burst still completes; DONE returns A2.
  - miss_cnt=1.
- Hit after refill: fetch 0x100C.
  - core_wait=0 in the same cycle and core_out=A3.
  - hit_cnt=1 and I_req stays 0.
- Two-way conflict and PLRU: fill 0x1000 (way 0) and 0x2000 (way 1), hit 0x1000, then fetch 0x3000.
  - The refill evicts way 1; a later fetch of 0x1000 hits and 0x2000 misses.
- Flush: in IDLE, flush together with core_req at 0x1000.
  - core_wait=1 in that cycle; the next cycle misses.
  - A flush during REFILL still returns the correct word in DONE; the subsequent fetch of that line misses.
- Reset mid-REFILL: drop rst after beat 1.
  - I_req=0 immediately and all counters are 0.
  - After reset releases, refetching the same address misses.
- Saturation: CNT_W=3; 9 consecutive hits leave hit_cnt=7.
